// File: rtl/alu_arb.sv
// alu_arb: one shared ALU behind a two-requester valid/ready arbiter with a registered response slot.
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.

module alu #(
    parameter int DATA_WIDTH = 32,
    parameter int TYPE_WIDTH = 4
) (
    input  logic [TYPE_WIDTH-1:0] i_alu_type,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_zero,
    output logic                  o_over,
    output logic                  o_neg
);
    localparam int SH_W = $clog2(DATA_WIDTH);
    localparam int MSB  = DATA_WIDTH - 1;

    localparam logic [TYPE_WIDTH-1:0] OP_ADD  = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] OP_SUB  = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] OP_AND  = TYPE_WIDTH'(2);
    localparam logic [TYPE_WIDTH-1:0] OP_OR   = TYPE_WIDTH'(3);
    localparam logic [TYPE_WIDTH-1:0] OP_XOR  = TYPE_WIDTH'(4);
    localparam logic [TYPE_WIDTH-1:0] OP_SLL  = TYPE_WIDTH'(5);
    localparam logic [TYPE_WIDTH-1:0] OP_SRL  = TYPE_WIDTH'(6);
    localparam logic [TYPE_WIDTH-1:0] OP_SRA  = TYPE_WIDTH'(7);
    localparam logic [TYPE_WIDTH-1:0] OP_SLT  = TYPE_WIDTH'(8);
    localparam logic [TYPE_WIDTH-1:0] OP_SLTU = TYPE_WIDTH'(9);

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [SH_W-1:0]       shamt;
    logic                  a_msb;
    logic                  b_msb;

    assign sum   = i_rs1_data + i_rs2_data;
    assign diff  = i_rs1_data - i_rs2_data;
    assign shamt = i_rs2_data[SH_W-1:0];
    assign a_msb = i_rs1_data[MSB];
    assign b_msb = i_rs2_data[MSB];

    // Overflow is only meaningful for signed add/sub; other ops report 0.
    always_comb begin
        o_res  = '0;
        o_over = 1'b0;
        case (i_alu_type)
            OP_ADD: begin
                o_res  = sum;
                o_over = (a_msb == b_msb) && (sum[MSB] != a_msb);
            end
            OP_SUB: begin
                o_res  = diff;
                o_over = (a_msb != b_msb) && (diff[MSB] != a_msb);
            end
            OP_AND:  o_res = i_rs1_data & i_rs2_data;
            OP_OR:   o_res = i_rs1_data | i_rs2_data;
            OP_XOR:  o_res = i_rs1_data ^ i_rs2_data;
            OP_SLL:  o_res = i_rs1_data << shamt;
            OP_SRL:  o_res = i_rs1_data >> shamt;
            OP_SRA:  o_res = DATA_WIDTH'($signed(i_rs1_data) >>> shamt);
            OP_SLT:  o_res = DATA_WIDTH'($signed(i_rs1_data) < $signed(i_rs2_data));
            OP_SLTU: o_res = DATA_WIDTH'(i_rs1_data < i_rs2_data);
            default: o_res = '0;
        endcase
        o_zero = (o_res == '0);
        o_neg  = o_res[MSB];
    end
endmodule

module alu_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int TYPE_WIDTH = 4
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [TYPE_WIDTH-1:0] i_req0_alu_type,
    input  logic [DATA_WIDTH-1:0] i_req0_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_req0_rs2_data,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [TYPE_WIDTH-1:0] i_req1_alu_type,
    input  logic [DATA_WIDTH-1:0] i_req1_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_req1_rs2_data,
    output logic                  o_rsp0_valid,
    input  logic                  i_rsp0_ready,
    output logic [DATA_WIDTH-1:0] o_rsp0_res,
    output logic                  o_rsp0_zero,
    output logic                  o_rsp0_over,
    output logic                  o_rsp0_neg,
    output logic                  o_rsp1_valid,
    input  logic                  i_rsp1_ready,
    output logic [DATA_WIDTH-1:0] o_rsp1_res,
    output logic                  o_rsp1_zero,
    output logic                  o_rsp1_over,
    output logic                  o_rsp1_neg
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  zero_q, zero_d;
    logic                  over_q, over_d;
    logic                  neg_q, neg_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                  last_q, last_d;
`endif

    logic                  own_ready;
    logic                  slot_free;
    logic                  grant0;
    logic                  grant1;
    logic [TYPE_WIDTH-1:0] alu_type;
    logic [DATA_WIDTH-1:0] alu_rs1;
    logic [DATA_WIDTH-1:0] alu_rs2;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_zero;
    logic                  alu_over;
    logic                  alu_neg;

    // Reset gates the grant so no ready escapes while the slot is being cleared.
    always_comb begin
        own_ready = owner_q ? i_rsp1_ready : i_rsp0_ready;
        slot_free = i_sys_rst_n && ((state_q == S_IDLE) || own_ready);
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (slot_free) begin
            if (i_req0_valid && i_req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                grant0 = 1'b1;
`else
                grant0 = last_q;
                grant1 = !last_q;
`endif
            end else begin
                grant0 = i_req0_valid;
                grant1 = i_req1_valid;
            end
        end
    end

    assign alu_type = grant1 ? i_req1_alu_type : i_req0_alu_type;
    assign alu_rs1  = grant1 ? i_req1_rs1_data : i_req0_rs1_data;
    assign alu_rs2  = grant1 ? i_req1_rs2_data : i_req0_rs2_data;

    alu #(
        .DATA_WIDTH(DATA_WIDTH),
        .TYPE_WIDTH(TYPE_WIDTH)
    ) u_alu (
        .i_alu_type(alu_type),
        .i_rs1_data(alu_rs1),
        .i_rs2_data(alu_rs2),
        .o_res     (alu_res),
        .o_zero    (alu_zero),
        .o_over    (alu_over),
        .o_neg     (alu_neg)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        res_d   = res_q;
        zero_d  = zero_q;
        over_d  = over_q;
        neg_d   = neg_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        if (grant0 || grant1) begin
            state_d = S_RESP;
            owner_d = grant1;
            res_d   = alu_res;
            zero_d  = alu_zero;
            over_d  = alu_over;
            neg_d   = alu_neg;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_d  = grant1;
`endif
        end else if (slot_free) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            over_q  <= 1'b0;
            neg_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            over_q  <= over_d;
            neg_q   <= neg_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    assign o_rsp0_valid = (state_q == S_RESP) && !owner_q;
    assign o_rsp1_valid = (state_q == S_RESP) && owner_q;

    assign o_rsp0_res  = {DATA_WIDTH{o_rsp0_valid}} & res_q;
    assign o_rsp0_zero = o_rsp0_valid & zero_q;
    assign o_rsp0_over = o_rsp0_valid & over_q;
    assign o_rsp0_neg  = o_rsp0_valid & neg_q;

    assign o_rsp1_res  = {DATA_WIDTH{o_rsp1_valid}} & res_q;
    assign o_rsp1_zero = o_rsp1_valid & zero_q;
    assign o_rsp1_over = o_rsp1_valid & over_q;
    assign o_rsp1_neg  = o_rsp1_valid & neg_q;
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed stimulus for alu_arb, checked every cycle against a
// transaction-level model of the shared slot, plus hand-computed pinned values.

module tb_alu_arb;
    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] AND  = 4'd2;
    localparam logic [3:0] OR   = 4'd3;
    localparam logic [3:0] XOR  = 4'd4;
    localparam logic [3:0] SLL  = 4'd5;
    localparam logic [3:0] SRL  = 4'd6;
    localparam logic [3:0] SRA  = 4'd7;
    localparam logic [3:0] SLT  = 4'd8;
    localparam logic [3:0] SLTU = 4'd9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, rr0 = 1'b0, rr1 = 1'b0;
    logic [3:0]  t0 = '0, t1 = '0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        r0, r1, sv0, sv1;
    logic [31:0] res0, res1;
    logic        z0, o0, n0, z1, o1, n1;

    int checks = 0;
    int errors = 0;

    logic        pin_en = 1'b0;
    logic [1:0]  pin_rdy = '0, pin_v = '0;
    logic [31:0] pin_res = '0;
    logic        pin_z = 1'b0, pin_o = 1'b0, pin_n = 1'b0;

    typedef struct packed {
        logic        owner;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        n;
    } entry_t;

    entry_t slot[$];
    logic   m_last = 1'b1;

    always #5 clk = ~clk;

    alu_arb #(.DATA_WIDTH(32), .TYPE_WIDTH(4)) dut (
        .i_sys_clk      (clk),
        .i_sys_rst_n    (rst_n),
        .i_req0_valid   (v0),
        .o_req0_ready   (r0),
        .i_req0_alu_type(t0),
        .i_req0_rs1_data(a0),
        .i_req0_rs2_data(b0),
        .i_req1_valid   (v1),
        .o_req1_ready   (r1),
        .i_req1_alu_type(t1),
        .i_req1_rs1_data(a1),
        .i_req1_rs2_data(b1),
        .o_rsp0_valid   (sv0),
        .i_rsp0_ready   (rr0),
        .o_rsp0_res     (res0),
        .o_rsp0_zero    (z0),
        .o_rsp0_over    (o0),
        .o_rsp0_neg     (n0),
        .o_rsp1_valid   (sv1),
        .i_rsp1_ready   (rr1),
        .o_rsp1_res     (res1),
        .o_rsp1_zero    (z1),
        .o_rsp1_over    (o1),
        .o_rsp1_neg     (n1)
    );

    // Returns {res, zero, over, neg} from plain signed/unsigned arithmetic.
    function automatic logic [34:0] model_alu(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, wide;
        logic [31:0] r;
        logic        ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        ov = 1'b0;
        case (op)
            ADD: begin
                wide = sa + sb;
                r    = a + b;
                ov   = (wide != longint'($signed(r)));
            end
            SUB: begin
                wide = sa - sb;
                r    = a - b;
                ov   = (wide != longint'($signed(r)));
            end
            AND:  r = a & b;
            OR:   r = a | b;
            XOR:  r = a ^ b;
            SLL:  r = a << b[4:0];
            SRL:  r = a >> b[4:0];
            SRA:  r = $signed(a) >>> b[4:0];
            SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            SLTU: r = (a < b) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {r, (r == 32'd0), ov, r[31]};
    endfunction

    function automatic logic [1:0] grant_of();
        logic free;
        free = (slot.size() == 0) || (slot[0].owner ? rr1 : rr0);
        if (!rst_n || !free) return 2'b00;
        if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 2'b01;
`else
            return m_last ? 2'b01 : 2'b10;
`endif
        end
        return {v1, v0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    initial begin : compare
        logic [1:0]  eg, ev;
        logic [34:0] e0, e1, pv;
        entry_t      hd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                slot.delete();
                m_last = 1'b1;
            end
            eg = grant_of();
            ev = 2'b00;
            e0 = '0;
            e1 = '0;
            if (slot.size() != 0) begin
                hd = slot[0];
                if (hd.owner) begin
                    ev = 2'b10;
                    e1 = {hd.res, hd.z, hd.o, hd.n};
                end else begin
                    ev = 2'b01;
                    e0 = {hd.res, hd.z, hd.o, hd.n};
                end
            end
            chk("req_ready", {r1, r0}, eg);
            chk("rsp_valid", {sv1, sv0}, ev);
            chk("rsp0_data", {res0, z0, o0, n0}, e0);
            chk("rsp1_data", {res1, z1, o1, n1}, e1);
            if (pin_en) begin
                pv = pin_v[1] ? {res1, z1, o1, n1} : {res0, z0, o0, n0};
                chk("pin_ready", {r1, r0}, pin_rdy);
                chk("pin_valid", {sv1, sv0}, pin_v);
                chk("pin_rsp", pv, {pin_res, pin_z, pin_o, pin_n});
                chk("model_vs_pin", {eg, ev, pin_v[1] ? e1 : e0},
                    {pin_rdy, pin_v, pin_res, pin_z, pin_o, pin_n});
            end
            @(posedge clk);
            if (!rst_n) begin
                slot.delete();
                m_last = 1'b1;
            end else begin
                eg = grant_of();
                if (slot.size() != 0 && (slot[0].owner ? rr1 : rr0))
                    void'(slot.pop_front());
                if (eg != 2'b00) begin
                    hd.owner = eg[1];
                    {hd.res, hd.z, hd.o, hd.n} = eg[1] ? model_alu(t1, a1, b1)
                                                       : model_alu(t0, a0, b0);
                    slot.push_back(hd);
                    m_last = eg[1];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        pin_en = 1'b0;
    endtask

    task automatic pin(input logic [1:0] rdy, input logic [1:0] v,
                       input logic [31:0] res, input logic z,
                       input logic o, input logic n);
        pin_en  = 1'b1;
        pin_rdy = rdy;
        pin_v   = v;
        pin_res = res;
        pin_z   = z;
        pin_o   = o;
        pin_n   = n;
    endtask

    task automatic req0(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
        v0 = 1'b1; t0 = t; a0 = a; b0 = b;
    endtask

    task automatic req1(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
        v1 = 1'b1; t1 = t; a1 = a; b1 = b;
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = {AND,  32'hF0F0_1234, 32'h0FF0_FFFF};
        vecs[1] = {OR,   32'h0000_00F0, 32'h0000_000F};
        vecs[2] = {XOR,  32'hAAAA_AAAA, 32'hAAAA_AAAA};
        vecs[3] = {SLL,  32'h0000_0001, 32'h0000_001F};
        vecs[4] = {SRL,  32'h8000_0000, 32'h0000_0004};
        vecs[5] = {SLTU, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[6] = {SUB,  32'h0000_0003, 32'h0000_0005};
        vecs[7] = {ADD,  32'h8000_0000, 32'h8000_0000};

        // Reset: outputs quiet even with a request pending.
        step();
        req0(ADD, 32'h5, 32'h7);
        pin(2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

        // 1: single request.
        step();
        rst_n = 1'b1;
        rr0 = 1'b1;
        pin(2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        v0 = 1'b0;
        pin(2'b00, 2'b01, 32'hC, 1'b0, 1'b0, 1'b0);
        step();
        pin(2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

        // 2: contention straight out of reset.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rr0 = 1'b1;
        rr1 = 1'b1;
        req0(ADD, 32'h1, 32'h2);
        req1(SUB, 32'h5, 32'h5);
        pin(2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        v0 = 1'b0;
        pin(2'b10, 2'b01, 32'h3, 1'b0, 1'b0, 1'b0);
        step();
        v1 = 1'b0;
        pin(2'b00, 2'b10, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        req0(ADD, 32'h1, 32'h2);
        req1(SUB, 32'h5, 32'h5);
`ifdef ALU_ARB_FIXED_PRIO_EN
        pin(2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        pin(2'b01, 2'b01, 32'h3, 1'b0, 1'b0, 1'b0);
        step();
        pin(2'b01, 2'b01, 32'h3, 1'b0, 1'b0, 1'b0);
        step();
        pin(2'b01, 2'b01, 32'h3, 1'b0, 1'b0, 1'b0);
        step();
        v0 = 1'b0;
        v1 = 1'b0;
        pin(2'b00, 2'b01, 32'h3, 1'b0, 1'b0, 1'b0);
`else
        pin(2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        pin(2'b10, 2'b01, 32'h3, 1'b0, 1'b0, 1'b0);
        step();
        pin(2'b01, 2'b10, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        pin(2'b10, 2'b01, 32'h3, 1'b0, 1'b0, 1'b0);
        step();
        v0 = 1'b0;
        v1 = 1'b0;
        pin(2'b00, 2'b10, 32'h0, 1'b1, 1'b0, 1'b0);
`endif
        step();
        pin(2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

        // 3: backpressure on requester 0; rsp1 ready from a non-owner is ignored.
        step();
        rr0 = 1'b0;
        req0(ADD, 32'h20, 32'h1);
        pin(2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            v0 = 1'b0;
            req1(ADD, 32'h30, 32'h4);
            pin(2'b00, 2'b01, 32'h21, 1'b0, 1'b0, 1'b0);
        end
        step();
        rr0 = 1'b1;
        pin(2'b10, 2'b01, 32'h21, 1'b0, 1'b0, 1'b0);
        step();
        v1 = 1'b0;
        pin(2'b00, 2'b10, 32'h34, 1'b0, 1'b0, 1'b0);

        // 4: back-to-back on requester 1.
        for (int i = 0; i < 4; i++) begin
            step();
            req1(ADD, 32'h10, 32'(i));
            if (i == 0) pin(2'b10, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
            else        pin(2'b10, 2'b10, 32'h10 + 32'(i - 1), 1'b0, 1'b0, 1'b0);
        end
        step();
        v1 = 1'b0;
        pin(2'b00, 2'b10, 32'h13, 1'b0, 1'b0, 1'b0);

        // 5: signed overflow in both directions.
        step();
        req1(ADD, 32'h7FFF_FFFF, 32'h1);
        pin(2'b10, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        req1(SUB, 32'h8000_0000, 32'h1);
        pin(2'b10, 2'b10, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        step();
        v1 = 1'b0;
        pin(2'b00, 2'b10, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);

        // Remaining operation types, checked by the model each cycle.
        for (int i = 0; i < 8; i++) begin
            step();
            req0(vecs[i].op, vecs[i].a, vecs[i].b);
        end
        step();
        req0(SRA, 32'h8000_0000, 32'h4);
        step();
        req0(SLT, 32'hFFFF_FFFF, 32'h1);
        pin(2'b01, 2'b01, 32'hF800_0000, 1'b0, 1'b0, 1'b1);
        step();
        v0 = 1'b0;
        pin(2'b00, 2'b01, 32'h1, 1'b0, 1'b0, 1'b0);

        // 6: reset while a response is held.
        step();
        rr0 = 1'b0;
        req0(ADD, 32'h9, 32'h9);
        pin(2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        v0 = 1'b0;
        pin(2'b00, 2'b01, 32'h12, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        req0(ADD, 32'h2, 32'h3);
        pin(2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        pin(2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        v0 = 1'b0;
        rr0 = 1'b1;
        pin(2'b00, 2'b01, 32'h5, 1'b0, 1'b0, 1'b0);
        step();
        pin(2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arb.md
Name: alu_arb

Overview:
- Two-requester arbiter that shares one `alu` instance between the execute path (requester 0) and the load/store address path (requester 1).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The ALU result and flags are registered in a single response slot.
- Sits between the decode/execute stage and the LSU, in place of a second ALU copy.

Parameters:
- DATA_WIDTH, `DATA_WIDTH, width of operands and result.
- TYPE_WIDTH, `ARGS_WIDTH, width of the ALU operation type.

Ports:
- i_sys_clk  in  1  clock; all state updates on rising edge.
- i_sys_rst_n  in  1  asynchronous active-low reset.
- i_req0_valid  in  1  requester 0 has an operation.
- o_req0_ready  out  1  requester 0 granted this cycle.
- i_req0_alu_type  in  TYPE_WIDTH  requester 0 operation.
- i_req0_rs1_data  in  DATA_WIDTH  requester 0 operand 1.
- i_req0_rs2_data  in  DATA_WIDTH  requester 0 operand 2.
- i_req1_valid, o_req1_ready, i_req1_alu_type, i_req1_rs1_data, i_req1_rs2_data: same as requester 0, for requester 1.
- o_rsp0_valid  out  1  response for requester 0 available.
- i_rsp0_ready  in  1  requester 0 accepts its response.
- o_rsp0_res  out  DATA_WIDTH  ALU result.
- o_rsp0_zero / o_rsp0_over / o_rsp0_neg  out  1 each  ALU flags.
- o_rsp1_valid, i_rsp1_ready, o_rsp1_res, o_rsp1_zero, o_rsp1_over, o_rsp1_neg: same as requester 0, for requester 1.

Behaviour:
- Reset (asynchronous, i_sys_rst_n=0):
  - state IDLE; response slot empty; owner=0; last-grant pointer=1.
  - All o_* outputs 0. All outputs are also 0 whenever the slot is not valid for that requester.
- State machine:
  - IDLE: slot empty.
  - RESP: slot holds the registered result for requester "owner".
- Slot is free this cycle if state==IDLE, or state==RESP and the owner's i_rspN_ready=1 (drain and refill in the same cycle).
- Grant, evaluated only when the slot is free:
  - Only one valid request: grant it.
  - Both valid: round-robin, grant the requester not recorded in last-grant.
  - Neither valid: no grant; a drained slot goes to IDLE.
- Grant is combinational:
  - o_reqN_ready=1 only for the granted requester; never both.
  - The granted operands drive the ALU.
  - Result and flags are registered into the slot; owner=N; last-grant=N; state RESP.
- Latency:
  - Request accepted in cycle T -> o_rspN_valid=1 from cycle T+1.
  - Response held stable until i_rspN_ready=1.
  - Throughput: 1 operation per cycle when responses are drained immediately.
- Only the owner's o_rspN_valid is ever high; the other response port stays 0.
- Slot occupied and not draining: both o_reqN_ready=0, request inputs ignored.
- Requesters must hold request inputs stable while valid and not ready; the arbiter does not check this.
- i_rspN_ready while that requester is not the owner: ignored.
- Reset asserted mid-operation: pending response discarded, outputs 0 immediately, no grant on the first clock edge after release unless a request is valid.
- Contention starvation bound: a continuously-valid requester is granted within 2 grants.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN defined:
  - Requester 0 always wins contention; last-grant pointer is unused (not synthesized).
  - Requester 1 can starve under continuous requester 0 traffic.
- Undefined: round-robin as above.

Test Plan:
1. Reset; single request: req0 valid, add type, rs1=0x5, rs2=0x7 at T.
   -> o_req0_ready=1 at T; o_rsp0_valid=1, o_rsp0_res=0x0000000C, zero=0 at T+1; o_rsp1_valid=0 throughout.
2. Contention from reset: both requests valid at T; req0 = add 1+2, req1 = sub 5-5; rsp ready held high.
   -> T: req0 granted; T+1: rsp0 res=0x3 and req1 granted; T+2: rsp1 res=0x0, zero=1.
   -> With ALU_ARB_FIXED_PRIO_EN and req0 held valid: req1 never granted.
3. Backpressure: i_rsp0_ready=0 for 3 cycles after grant.
   -> rsp0 value and valid held stable; o_req0_ready=0 and o_req1_ready=0 during stall.
   -> The cycle i_rsp0_ready rises, a pending req1 is granted.
4. Back-to-back: req1 valid every cycle for 4 cycles with add 0x10+i; rsp1 ready high.
   -> 4 grants in 4 consecutive cycles; results 0x10..0x13 one cycle later each.
5. Overflow flag: req1 add rs1=0x7FFFFFFF, rs2=0x1.
   -> rsp1 res=0x80000000, over=1, neg=1.
6. Reset mid-operation: assert i_sys_rst_n=0 while the slot holds a response.
   -> All outputs 0 immediately; after release, a new req0 is granted within 1 cycle and no stale response appears.
